// File: rtl/multiport_data_memory.sv
// Shared data memory arbitrated round-robin between NUM_PORTS requesters.
// After reset the array is swept to zero before any request is granted.
module multiport_data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int NUM_PORTS  = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_rdata,
  output logic [NUM_PORTS-1:0]            rsp_error,
  output logic                            init_done
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IW-1:0]       LAST_WORD = IW'(DEPTH - 1);
  localparam logic [PW-1:0]       LAST_PORT = PW'(NUM_PORTS - 1);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          clear_ptr_q, clear_ptr_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]   rsp_valid_q, rsp_valid_d;
  logic [NUM_PORTS-1:0]   rsp_error_q, rsp_error_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0]  rsp_rdata_d [NUM_PORTS];
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0]  addr_a  [NUM_PORTS];
  logic [DATA_WIDTH-1:0]  wdata_a [NUM_PORTS];

  logic                   run_mode, clear_we;
  logic                   grant_found;
  logic [PW-1:0]          grant_idx, cand;
  logic [NUM_PORTS-1:0]   grant;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic                   sel_write, in_range, mem_we;
  logic [IW-1:0]          sel_idx;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign addr_a[i]                           = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[i]                          = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = rsp_rdata_q[i];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= CLEAR;
      clear_ptr_q <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_error_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) rsp_rdata_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // NOTE: every combinational output gets a default before any branch,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    case (state_q)
      CLEAR: begin
        if (clear_ptr_q == LAST_WORD) state_d = RUN;
        else                          clear_ptr_d = clear_ptr_q + 1'b1;
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    run_mode  = (state_q == RUN);
    clear_we  = (state_q == CLEAR);
    init_done = run_mode;
  end

  // First requesting port at or after rr_ptr, wrapping past the top port.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = PW'((int'(rr_ptr_q) + k) % NUM_PORTS);
      if (run_mode && !grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    grant = '0;
    if (grant_found) grant[grant_idx] = 1'b1;
  end

  assign req_ready = grant;

  always_comb begin
    sel_addr  = addr_a[grant_idx];
    sel_wdata = wdata_a[grant_idx];
    sel_write = req_write[grant_idx];
    in_range  = ({1'b0, sel_addr} < DEPTH_EXT);
    sel_idx   = sel_addr[IW-1:0];
    mem_we    = grant_found && sel_write && in_range && !reset;
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = '0;
    rsp_error_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    if (grant_found) begin
      rr_ptr_d               = (grant_idx == LAST_PORT) ? '0 : grant_idx + 1'b1;
      rsp_valid_d            = grant;
      rsp_error_d[grant_idx] = !in_range;
      // Reads see the word as it was before this edge's write.
      rsp_rdata_d[grant_idx] = (in_range && !sel_write) ? mem_q[sel_idx] : '0;
    end
  end

  // NOTE: the storage array has no reset branch; the CLEAR sweep zeroes it,
  // which keeps it mappable onto plain RAM.
  always_ff @(posedge clock) begin
    if (clear_we)    mem_q[clear_ptr_q] <= '0;
    else if (mem_we) mem_q[sel_idx]     <= sel_wdata;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: doc/multiport_data_memory.md
MULTIPORT_DATA_MEMORY -- requirements
Module: multiport_data_memory

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning request address width.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning number of words stored, with 1 <= DEPTH <= 2**ADDR_WIDTH.
REQ-004 The block SHALL have parameter NUM_PORTS, default 2, meaning number of requester channels, with NUM_PORTS >= 2.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 The block SHALL have port req_valid, input, NUM_PORTS bits: per-port request present.
REQ-008 The block SHALL have port req_write, input, NUM_PORTS bits: per-port 1=write, 0=read.
REQ-009 The block SHALL have port req_addr, input, NUM_PORTS*ADDR_WIDTH bits: port i in slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 The block SHALL have port req_wdata, input, NUM_PORTS*DATA_WIDTH bits: write data, sliced as for req_addr.
REQ-011 The block SHALL have port req_ready, output, NUM_PORTS bits: per-port grant.
REQ-012 The block SHALL have port rsp_valid, output, NUM_PORTS bits: per-port one-cycle response strobe.
REQ-013 The block SHALL have port rsp_rdata, output, NUM_PORTS*DATA_WIDTH bits: per-port read data.
REQ-014 The block SHALL have port rsp_error, output, NUM_PORTS bits: per-port out-of-range flag, valid with rsp_valid.
REQ-015 The block SHALL have port init_done, output, 1 bit: memory clear complete, requests accepted.

Function
REQ-016 The block SHALL implement an FSM with states CLEAR and RUN; reset forces CLEAR with clear pointer 0.
REQ-017 In CLEAR, the block SHALL write zero to word clear_ptr each cycle, incrementing the pointer, and go to RUN after writing word DEPTH-1, so RUN is entered exactly DEPTH cycles after reset deasserts.
REQ-018 In CLEAR, req_ready and init_done SHALL be 0; in RUN, init_done SHALL be 1.
REQ-019 In RUN, at most one bit of req_ready SHALL be 1 per cycle, combinationally granted to the first port with req_valid=1 searching round-robin from rr_ptr upward with wrap from NUM_PORTS-1 to 0.
REQ-020 A request SHALL be accepted on a cycle where req_valid[i] and req_ready[i] are both 1; requesters hold address, data and write stable until acceptance.
REQ-021 On acceptance, rr_ptr SHALL become (i+1) mod NUM_PORTS; without acceptance rr_ptr SHALL be unchanged; reset sets rr_ptr to 0.
REQ-022 An accepted write with addr < DEPTH SHALL update the word at that edge; an accepted read SHALL return the word's value before any same-edge write.
REQ-023 Exactly one cycle after acceptance, rsp_valid[i] SHALL be 1 for one cycle, with rsp_rdata slice = read word (0 for writes) and rsp_error[i]=0.
REQ-024 An accepted request with addr >= DEPTH SHALL NOT modify memory and SHALL respond with rsp_error[i]=1 and rsp_rdata slice 0.
REQ-025 Responses SHALL NOT be back-pressured; rsp_rdata of ports without rsp_valid SHALL hold their last value.
REQ-026 Sustained throughput SHALL be one accepted request per cycle across all ports.

Reset
REQ-027 On reset, rsp_valid, rsp_error, rsp_rdata, req_ready and init_done SHALL be 0 on the following cycle.
REQ-028 Reset during RUN SHALL discard any response due the next cycle and restart CLEAR from word 0.
REQ-029 Reset during CLEAR SHALL restart the clear pointer at 0.

Verification
(Parameters: DATA_WIDTH=32, ADDR_WIDTH=4, DEPTH=12, NUM_PORTS=3.)
REQ-030 Release reset, hold all req_valid=1 -> init_done rises exactly 12 cycles later; no req_ready before then; then reads of addr 0..11 return 0.
REQ-031 Port 1 writes 0xDEADBEEF to addr 5, then port 2 reads addr 5 -> port 1 rsp_valid one cycle after grant with rdata 0 and error 0; port 2 rdata 0xDEADBEEF one cycle after its grant.
REQ-032 All three ports request continuously from rr_ptr=0 -> grants 0,1,2,0,1,2 on consecutive cycles, one rsp_valid per cycle.
REQ-033 Port 0 writes 0x1234 to addr 13 -> rsp_error[0]=1, rdata 0; a subsequent read of addr 13 gives error 1; addr 13 mod 12 = 1 remains 0.
REQ-034 Same-cycle conflict: port 0 wins a read of addr 3, and port 2 write of 0xA5 to addr 3 is granted next cycle -> port 0 reads 0, then a later read gives 0xA5.
REQ-035 Reset asserted in the cycle after a read is granted -> no rsp_valid follows; init_done=0 for 12 cycles after release; a previously written word reads 0.
